// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring shift-subtract step per cycle.
// Define SIGNED_MD_EN to make op 01/11 signed; otherwise every operation is unsigned.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 is_div_q, is_div_d;
    logic                 dbz_q, dbz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dbz_out_q, dbz_out_d;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_upper;
    logic [WIDTH:0]       rem_sh, diff;
    logic [WIDTH-1:0]     res_hi, res_lo;

`ifdef SIGNED_MD_EN
    logic                 a_neg, b_neg;
    logic                 sign_q, sign_d;
    logic                 a_neg_q, a_neg_d;

    always_comb begin
        a_neg = op[0] & operand_a[WIDTH-1];
        b_neg = op[0] & operand_b[WIDTH-1];
        mag_a = a_neg ? -operand_a : operand_a;
        mag_b = b_neg ? -operand_b : operand_b;
    end
`else
    logic                 unused_op0;
    assign unused_op0 = op[0];

    always_comb begin
        mag_a = operand_a;
        mag_b = operand_b;
    end
`endif

    // Datapath steps; acc holds {partial product} for multiply, {remainder, quotient} for divide
    always_comb begin
        mul_upper = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff      = rem_sh - {1'b0, opnd_q};
    end

    always_comb begin
        res_hi = acc_q[2*WIDTH-1:WIDTH];
        res_lo = acc_q[WIDTH-1:0];
`ifdef SIGNED_MD_EN
        if (is_div_q) begin
            if (sign_q)  res_lo = -acc_q[WIDTH-1:0];
            if (a_neg_q) res_hi = -acc_q[2*WIDTH-1:WIDTH];
        end else if (sign_q) begin
            {res_hi, res_lo} = -acc_q;
        end
`endif
        // Divide by zero leaves the dividend magnitude as remainder, so only the quotient is forced
        if (dbz_q) res_lo = '1;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_out_d = 1'b0;
`ifdef SIGNED_MD_EN
        sign_d    = sign_q;
        a_neg_d   = a_neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wr_data;
                if (lo_we) lo_d = wr_data;
                if (start) begin
                    state_d  = S_CALC;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    dbz_d    = op[1] & (operand_b == '0);
                    opnd_d   = op[1] ? mag_b : mag_a;
                    acc_d    = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
`ifdef SIGNED_MD_EN
                    sign_d   = a_neg ^ b_neg;
                    a_neg_d  = a_neg;
`endif
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else              acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {mul_upper, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIN;
            end
            S_FIN: begin
                hi_d      = res_hi;
                lo_d      = res_lo;
                done_d    = 1'b1;
                dbz_out_d = dbz_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
`ifdef SIGNED_MD_EN
            sign_q    <= 1'b0;
            a_neg_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_out_q <= dbz_out_d;
`ifdef SIGNED_MD_EN
            sign_q    <= sign_d;
            a_neg_q   <= a_neg_d;
`endif
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_out_q;

endmodule
